alu_decode_stage: RTL

- Pipeline stage directly upstream of the 32-bit ALU.
- Accepts MIPS instruction words with their register-file operands over a valid/ready handshake.
- Decodes each word into the ALU operand pair (a, b), the 6-bit ALU opcode and writeback control, then registers the result.
- A 2-entry skid buffer keeps full throughput while cutting the ready path, so downstream stalls never combinationally reach the fetch/regfile side.

---
 rtl/alu_decode_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: MIPS decode stage in front of the 32-bit ALU.
// Decodes R-type ALU/shift ops and LUI into an ALU operand pair, opcode and
// writeback control, then registers the bundle behind a valid/ready handshake.
// A 2-entry buffer (output register + skid register) gives full throughput
// while in_ready depends only on registered state.
// Optional feature: define ALU_IMM_EN to decode the I-type ALU immediates
// (ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI); otherwise those opcodes are illegal.
module alu_decode_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_aluc,
  output logic [REG_AW-1:0] dest,
  output logic              wr_en,
  output logic              illegal
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [5:0]        aluc;
    logic [REG_AW-1:0] dest;
    logic              wr_en;
    logic              illegal;
  } bundle_t;

  localparam logic [5:0] ALUC_ADD = 6'b100000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rt_f;
  logic [REG_AW-1:0] rd_f;
  logic [4:0]        shamt;
  logic [15:0]       imm16;
  logic [4:0]        unused_rs_field;

  assign opcode          = instr[31:26];
  assign funct           = instr[5:0];
  assign rt_f            = instr[20:16];
  assign rd_f            = instr[15:11];
  assign shamt           = instr[10:6];
  assign imm16           = instr[15:0];
  // rs operand arrives pre-read as rs_data; the address field itself is not needed.
  assign unused_rs_field = instr[25:21];

  bundle_t dec;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_valid_q, skid_valid_d;

  // Decode the incoming word; anything unrecognised becomes the illegal bundle.
  always_comb begin
    dec         = '0;
    dec.aluc    = ALUC_ADD;
    dec.illegal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: begin
            dec.illegal = 1'b0;
            dec.aluc    = funct;
            dec.a       = rs_data;
            dec.b       = rt_data;
            dec.dest    = rd_f;
          end
          6'b000000, 6'b000010, 6'b000011: begin
            dec.illegal = 1'b0;
            dec.aluc    = funct;
            dec.a       = rt_data;
            dec.b       = {{(DATA_W-5){1'b0}}, shamt};
            dec.dest    = rd_f;
          end
          6'b000100, 6'b000110, 6'b000111: begin
            dec.illegal = 1'b0;
            dec.aluc    = funct;
            dec.a       = rs_data;
            dec.b       = rt_data;
            dec.dest    = rd_f;
          end
          default: ;
        endcase
      end
      OP_LUI: begin
        dec.illegal = 1'b0;
        dec.aluc    = OP_LUI;
        dec.a       = {{(DATA_W-16){1'b0}}, imm16};
        dec.b       = '0;
        dec.dest    = rt_f;
      end
`ifdef ALU_IMM_EN
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110: begin
        dec.illegal = 1'b0;
        dec.a       = rs_data;
        dec.dest    = rt_f;
        // opcode[2] separates the logical ops (zero-extend) from arithmetic/compare (sign-extend).
        dec.b       = opcode[2] ? {{(DATA_W-16){1'b0}}, imm16}
                                : {{(DATA_W-16){imm16[15]}}, imm16};
        case (opcode[2:0])
          3'd0:    dec.aluc = 6'b100000;
          3'd1:    dec.aluc = 6'b100001;
          3'd2:    dec.aluc = 6'b101010;
          3'd3:    dec.aluc = 6'b101011;
          3'd4:    dec.aluc = 6'b100100;
          3'd5:    dec.aluc = 6'b100101;
          3'd6:    dec.aluc = 6'b100110;
          default: dec.aluc = ALUC_ADD;
        endcase
      end
`endif
      default: ;
    endcase
    dec.wr_en = ~dec.illegal & (dec.dest != '0);
  end

  // Ready depends only on skid occupancy (and is held low in reset).
  assign in_ready = ~skid_valid_q & ~rst;

  // Next-state for the output/skid pair; skid only fills while the output stalls.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_valid) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; reset clears both entries and all output fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = out_q.a;
  assign alu_b     = out_q.b;
  assign alu_aluc  = out_q.aluc;
  assign dest      = out_q.dest;
  assign wr_en     = out_q.wr_en;
  assign illegal   = out_q.illegal;

endmodule
